// File: rtl/acl2_sequencer_pkg.sv
// +--------------------------------------------------------------------------+
// | acl2_pkg : ADXL362-style command bytes, registers and state types         |
// | Revision : 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package acl2_pkg;

   localparam logic [7:0] c_cmd_write      = 8'h0A;
   localparam logic [7:0] c_cmd_read       = 8'h0B;

   localparam logic [7:0] c_reg_devid      = 8'h00;
   localparam logic [7:0] c_reg_xdata      = 8'h0E;
   localparam logic [7:0] c_reg_soft_reset = 8'h1F;
   localparam logic [7:0] c_reg_intmap1    = 8'h2A;
   localparam logic [7:0] c_reg_power_ctl  = 8'h2D;

   localparam logic [7:0] c_val_soft_reset = 8'h52;
   localparam logic [7:0] c_val_int_drdy   = 8'h01;
   localparam logic [7:0] c_val_measure    = 8'h02;
   localparam logic [7:0] c_devid          = 8'hAD;

   localparam int c_max_bytes = 8;

   typedef logic [c_max_bytes-1:0][7:0] byte_list_t;

   typedef enum logic [2:0] {
      S_SRST,
      S_SRWAIT,
      S_CFG,
      S_IDCHK,
      S_IDLE,
      S_BURST,
      S_GAP,
      S_ERR
   } seq_state_t;

   typedef enum logic [1:0] {
      X_IDLE,
      X_CS,
      X_WAIT,
      X_FAULT
   } xfer_state_t;

   function automatic byte_list_t pack3(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2);
      byte_list_t l;
      l    = '0;
      l[0] = b0;
      l[1] = b1;
      l[2] = b2;
      return l;
   endfunction

   function automatic logic [11:0] axis12(input logic [7:0] lo, input logic [7:0] hi);
      return {hi[3:0], lo};
   endfunction

endpackage

`default_nettype wire

// File: rtl/acl2_sequencer_if.sv
// +--------------------------------------------------------------------------+
// | acl2_sequencer_if : byte-level handshake to the SPI byte engine            |
// | Revision : 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface acl2_sequencer_if;
   logic       spi_cs;
   logic       spi_start;
   logic [7:0] spi_tx;
   logic       spi_done;
   logic [7:0] spi_rx;

   modport master (
      output spi_cs,
      output spi_start,
      output spi_tx,
      input  spi_done,
      input  spi_rx
   );

   modport slave (
      input  spi_cs,
      input  spi_start,
      input  spi_tx,
      output spi_done,
      output spi_rx
   );
endinterface

`default_nettype wire

// File: rtl/acl2_sequencer_xfer.sv
// +--------------------------------------------------------------------------+
// | acl2_xfer : runs one chip-selected list of byte exchanges with timeout     |
// | Revision : 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module acl2_xfer
   import acl2_pkg::*;
#(
   parameter int unsigned BYTE_TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    go,
   input  logic [3:0]              len,
   input  byte_list_t              tx_bytes,
   output logic                    finish,
   output logic                    fault,
   output byte_list_t              rx_bytes,
   acl2_sequencer_if.master        spi
);

   xfer_state_t r_state;
   logic [2:0]  r_idx;
   logic [31:0] r_cnt;
   byte_list_t  r_rx;
   logic        r_cs;
   logic        r_start;
   logic        r_fault;
   logic [7:0]  r_tx;

   logic w_last;
   logic w_byte_done;

   assign w_last      = ({1'b0, r_idx} == (len - 4'd1));
   assign w_byte_done = (r_state == X_WAIT) && spi.spi_done;
   assign finish      = w_byte_done && w_last;
   assign fault       = r_fault;

   assign spi.spi_cs    = r_cs;
   assign spi.spi_start = r_start;
   assign spi.spi_tx    = r_tx;

   // The byte arriving right now is forwarded so the caller can act on the final done.
   always_comb begin
      rx_bytes = r_rx;
      if (w_byte_done) begin
         rx_bytes[r_idx] = spi.spi_rx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= X_IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_rx    <= '0;
         r_cs    <= 1'b0;
         r_start <= 1'b0;
         r_fault <= 1'b0;
         r_tx    <= '0;
      end else begin
         r_start <= 1'b0;
         case (r_state)
            X_IDLE: begin
               if (go) begin
                  r_cs    <= 1'b1;
                  r_idx   <= '0;
                  r_state <= X_CS;
               end
            end
            X_CS: begin
               r_start <= 1'b1;
               r_tx    <= tx_bytes[r_idx];
               r_cnt   <= '0;
               r_state <= X_WAIT;
            end
            X_WAIT: begin
               if (spi.spi_done) begin
                  r_rx[r_idx] <= spi.spi_rx;
                  if (w_last) begin
                     r_cs    <= 1'b0;
                     r_state <= X_IDLE;
                  end else begin
                     r_idx   <= r_idx + 3'd1;
                     r_start <= 1'b1;
                     r_tx    <= tx_bytes[r_idx + 3'd1];
                     r_cnt   <= '0;
                  end
               end else if (r_cnt == BYTE_TIMEOUT) begin
                  r_cs    <= 1'b0;
                  r_fault <= 1'b1;
                  r_state <= X_FAULT;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            X_FAULT: begin
               r_state <= X_FAULT;
            end
            default: begin
               r_state <= X_FAULT;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/acl2_sequencer.sv
// +--------------------------------------------------------------------------+
// | acl2_sequencer : ACL2 init, ID check and interrupt-driven XYZ bursts       |
// | Revision : 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module acl2_sequencer
   import acl2_pkg::*;
#(
   parameter int unsigned SRST_WAIT    = 50000,
   parameter int unsigned CS_GAP       = 8,
   parameter int unsigned POLL_PERIOD  = 0,
   parameter int unsigned BYTE_TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   acl2_sequencer_if.master spi,
   input  logic             int_in,
   output logic             init_done,
   output logic             error,
   output logic             sample_valid,
   output logic [11:0]      x,
   output logic [11:0]      y,
   output logic [11:0]      z
);

   seq_state_t  r_state;
   seq_state_t  r_after_gap;
   logic        r_launched;
   logic        r_go;
   logic        r_cfg_step;
   logic        r_pending;
   logic        r_id_err;
   logic        r_init_done;
   logic        r_sample_valid;
   logic [31:0] r_cnt;
   logic [31:0] r_poll_cnt;
   logic [1:0]  r_int_sync;
   logic        r_int_prev;
   logic [11:0] r_x;
   logic [11:0] r_y;
   logic [11:0] r_z;

   byte_list_t  w_txn_list;
   logic [3:0]  w_txn_len;
   byte_list_t  w_rx;
   logic        w_finish;
   logic        w_fault;
   logic        w_txn_state;
   logic        w_int_rise;
   logic        w_poll_exp;
   logic        w_trigger;
   logic        w_start_burst;
   logic        w_unused_rx;

   acl2_xfer #(
      .BYTE_TIMEOUT (BYTE_TIMEOUT)
   ) u_xfer (
      .clk      (clk),
      .rst      (rst),
      .go       (r_go),
      .len      (w_txn_len),
      .tx_bytes (w_txn_list),
      .finish   (w_finish),
      .fault    (w_fault),
      .rx_bytes (w_rx),
      .spi      (spi)
   );

   assign w_unused_rx   = ^{w_rx[1], w_rx[0]};
   assign w_txn_state   = (r_state == S_SRST) || (r_state == S_CFG) ||
                          (r_state == S_IDCHK) || (r_state == S_BURST);
   assign w_int_rise    = r_int_sync[1] & ~r_int_prev;
   assign w_poll_exp    = (POLL_PERIOD != 0) && r_init_done &&
                          (r_poll_cnt == POLL_PERIOD - 1);
   assign w_trigger     = r_init_done && (w_int_rise || w_poll_exp);
   assign w_start_burst = (r_state == S_IDLE) && (w_trigger || r_pending) && !w_fault;

   assign init_done    = r_init_done;
   assign error        = r_id_err | w_fault;
   assign sample_valid = r_sample_valid;
   assign x            = r_x;
   assign y            = r_y;
   assign z            = r_z;

   // Byte list is stable for the whole transaction because it only depends on state.
   always_comb begin
      w_txn_list = '0;
      w_txn_len  = 4'd3;
      case (r_state)
         S_SRST:  w_txn_list = pack3(c_cmd_write, c_reg_soft_reset, c_val_soft_reset);
         S_CFG:   w_txn_list = r_cfg_step ? pack3(c_cmd_write, c_reg_power_ctl, c_val_measure)
                                          : pack3(c_cmd_write, c_reg_intmap1, c_val_int_drdy);
         S_IDCHK: w_txn_list = pack3(c_cmd_read, c_reg_devid, 8'h00);
         S_BURST: begin
            w_txn_list[0] = c_cmd_read;
            w_txn_list[1] = c_reg_xdata;
            w_txn_len     = 4'd8;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_int_sync <= '0;
         r_int_prev <= 1'b0;
         r_poll_cnt <= '0;
      end else begin
         r_int_sync <= {r_int_sync[0], int_in};
         r_int_prev <= r_int_sync[1];
         if ((POLL_PERIOD == 0) || !r_init_done || w_start_burst || w_poll_exp) begin
            r_poll_cnt <= '0;
         end else begin
            r_poll_cnt <= r_poll_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_SRST;
         r_after_gap    <= S_SRST;
         r_launched     <= 1'b0;
         r_go           <= 1'b0;
         r_cfg_step     <= 1'b0;
         r_pending      <= 1'b0;
         r_id_err       <= 1'b0;
         r_init_done    <= 1'b0;
         r_sample_valid <= 1'b0;
         r_cnt          <= '0;
         r_x            <= '0;
         r_y            <= '0;
         r_z            <= '0;
      end else begin
         r_go           <= 1'b0;
         r_sample_valid <= 1'b0;
         if (w_trigger && ((r_state == S_BURST) || (r_state == S_GAP))) begin
            r_pending <= 1'b1;
         end
         if (w_txn_state && !r_launched && !w_fault) begin
            r_go       <= 1'b1;
            r_launched <= 1'b1;
         end

         if (w_fault) begin
            r_state    <= S_ERR;
            r_launched <= 1'b0;
         end else begin
            case (r_state)
               S_SRST: begin
                  if (w_finish) begin
                     r_launched <= 1'b0;
                     r_cnt      <= '0;
                     r_state    <= S_SRWAIT;
                  end
               end
               S_SRWAIT: begin
                  if (r_cnt + 32'd1 >= SRST_WAIT) begin
                     r_cnt       <= '0;
                     r_after_gap <= S_CFG;
                     r_state     <= S_GAP;
                  end else begin
                     r_cnt <= r_cnt + 32'd1;
                  end
               end
               S_CFG: begin
                  if (w_finish) begin
                     r_launched  <= 1'b0;
                     r_cnt       <= '0;
                     r_cfg_step  <= 1'b1;
                     r_after_gap <= r_cfg_step ? S_IDCHK : S_CFG;
                     r_state     <= S_GAP;
                  end
               end
               S_IDCHK: begin
                  if (w_finish) begin
                     r_launched <= 1'b0;
                     r_cnt      <= '0;
                     if (w_rx[2] == c_devid) begin
                        r_init_done <= 1'b1;
                        r_after_gap <= S_IDLE;
                        r_state     <= S_GAP;
                     end else begin
                        r_id_err <= 1'b1;
                        r_state  <= S_ERR;
                     end
                  end
               end
               S_IDLE: begin
                  if (w_start_burst) begin
                     r_pending <= 1'b0;
                     r_state   <= S_BURST;
                  end
               end
               S_BURST: begin
                  if (w_finish) begin
                     r_launched     <= 1'b0;
                     r_cnt          <= '0;
                     r_x            <= axis12(w_rx[2], w_rx[3]);
                     r_y            <= axis12(w_rx[4], w_rx[5]);
                     r_z            <= axis12(w_rx[6], w_rx[7]);
                     r_sample_valid <= 1'b1;
                     r_after_gap    <= S_IDLE;
                     r_state        <= S_GAP;
                  end
               end
               S_GAP: begin
                  if (r_cnt >= CS_GAP) begin
                     r_cnt   <= '0;
                     r_state <= r_after_gap;
                  end else begin
                     r_cnt <= r_cnt + 32'd1;
                  end
               end
               S_ERR: begin
                  r_state <= S_ERR;
               end
               default: begin
                  r_state <= S_ERR;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/acl2_sequencer.md
ACL2_SEQUENCER -- requirements
Module: acl2_sequencer

Interface
REQ-001 SHALL have parameter SRST_WAIT, default 50000, meaning cycles to wait after the soft-reset write (0.5 ms at 100 MHz).
REQ-002 SHALL have parameter CS_GAP, default 8, meaning minimum cycles CS stays deasserted between transactions.
REQ-003 SHALL have parameter POLL_PERIOD, default 0, meaning cycles between forced reads; 0 disables polling.
REQ-004 SHALL have parameter BYTE_TIMEOUT, default 1024, meaning maximum cycles from spi_start to spi_done.
REQ-005 Clock  input  1  single clock; all logic on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 spi_cs  output  1  chip select request to the SPI byte engine, 1 = selected.
REQ-008 spi_start  output  1  one-cycle pulse launching one byte exchange.
REQ-009 spi_tx  output  8  byte to shift out; valid while spi_start is high.
REQ-010 spi_done  input  1  one-cycle pulse ending the exchange.
REQ-011 spi_rx  input  8  received byte; valid only while spi_done is high.
REQ-012 int_in  input  1  raw ACL2 INT1 pin (asynchronous), data-ready, active high.
REQ-013 init_done  output  1  high once configuration and ID check have passed.
REQ-014 error  output  1  sticky; high after ID mismatch or byte timeout.
REQ-015 sample_valid  output  1  one-cycle pulse when x, y and z update.
REQ-016 x, y, z  output  12 each  two's-complement axis samples, held between updates.

Function
REQ-017 SHALL implement states S_SRST, S_SRWAIT, S_CFG, S_IDCHK, S_IDLE, S_BURST, S_GAP, S_ERR.
REQ-018 Transaction: assert spi_cs, then spi_start one cycle later; each subsequent spi_start occurs the cycle after the previous spi_done; spi_cs drops the cycle after the final spi_done.
REQ-019 Never more than one byte outstanding; spi_start is never asserted while a byte is in flight.
REQ-020 S_SRST: write 0x0A,0x1F,0x52, then S_SRWAIT for SRST_WAIT cycles.
REQ-021 S_CFG: write 0x0A,0x2A,0x01 (INTMAP1 = DATA_READY), then 0x0A,0x2D,0x02 (measurement mode), in that order.
REQ-022 S_IDCHK: read 0x0B,0x00,dummy; third rx byte == 0xAD -> init_done=1 and S_IDLE; otherwise error=1 and S_ERR.
REQ-023 CS_GAP cycles of spi_cs=0 (S_GAP) SHALL separate every pair of transactions, including init transactions.
REQ-024 int_in SHALL pass a 2-FF synchronizer; a trigger is a synchronized rising edge or poll-counter expiry.
REQ-025 S_IDLE on trigger -> S_BURST: send 0x0B,0x0E, then 6 dummy bytes 0x00 capturing X_L,X_H,Y_L,Y_H,Z_L,Z_H.
REQ-026 Assembly: axis = {H[3:0], L}; sample_valid pulses the cycle after the final spi_done, simultaneously with the x/y/z update.
REQ-027 One pending-trigger flag: a trigger during S_BURST/S_GAP sets it; additional triggers are dropped; a pending flag starts a burst immediately after S_GAP.
REQ-028 Simultaneous INT edge and poll expiry SHALL produce one burst; the poll counter reloads at every burst start.
REQ-029 Triggers before init_done are ignored and are not pending.
REQ-030 Timeout: spi_done absent BYTE_TIMEOUT cycles after spi_start -> spi_cs=0, error=1, S_ERR.
REQ-031 S_ERR is terminal until Reset; no spi_start is issued there.

Reset
REQ-032 While Reset is high: state=S_SRST, spi_cs=0, spi_start=0, spi_tx=0, init_done=0, error=0, sample_valid=0, x=y=z=0, pending=0, counters=0, synchronizer=0.
REQ-033 Reset mid-transaction SHALL drop spi_cs the next cycle and restart the full init sequence on release.

Structure
REQ-034 Shared package acl2_pkg SHALL hold the command bytes (0x0A, 0x0B), register addresses (0x00, 0x0E, 0x1F, 0x2A, 0x2D), config values, DEVID 0xAD and the state enum.
REQ-035 A single sub-module acl2_xfer SHALL run the byte loop: spi_cs, spi_start, timeout, and rx byte capture for a length-N byte list.

Verification
REQ-036 Reset release, SPI model echoing 0xAD on ID read -> MOSI bytes 0A 1F 52 | 0A 2A 01 | 0A 2D 02 | 0B 00 xx; init_done=1, error=0.
REQ-037 ID returns 0x00 -> error=1, no further spi_start within 10000 cycles.
REQ-038 int_in rising edge; model returns 34 F2 10 00 FF 0F -> sample_valid single pulse, x=0x234, y=0x010, z=0xFFF.
REQ-039 Three int_in edges during one burst -> exactly two bursts in total; CS low >= CS_GAP cycles between them.
REQ-040 Model withholds spi_done -> error=1 at BYTE_TIMEOUT+1 cycles, spi_cs=0.
REQ-041 Reset pulsed during 4th burst byte -> spi_cs=0 next cycle, init sequence repeats, no sample_valid.
